psram_spi_responder: RTL and testbench
======================================

Name: psram_spi_responder

Overview:
- Synthesizable SPI/QSPI target that answers the PSRAM master's bus: the far end of the SpiBus pins.
- Lives in the tangnano psram tree. It backs the master in loopback simulation and in on-board self-test, in place of the external PSRAM chip.
- Oversamples sclk/ce/sio with sysclk, decodes PSRAM command frames, and drives a byte-wide memory port.

Parameters:
- ADDR_WIDTH, 16, memory port address width; the 24-bit bus address is truncated to the low ADDR_WIDTH bits.
- QREAD_WAIT, 6, dummy sclk cycles between the last address nibble and the first data nibble of 0xEB.

Ports:
- sysclk  in  1  system clock; at least 8x sclk frequency.
- reset  in  1  synchronous, active-high.
- sclk  in  1  bus clock from the master.
- ce  in  1  chip enable, active-low.
- sio_in  in  4  bus data as seen at the pins.
- sio_out  out  4  data driven by the responder.
- sio_oe  out  4  per-line output enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  8  write byte.
- mem_we  out  1  one-cycle write strobe.
- mem_re  out  1  one-cycle read strobe.
- mem_rdata  in  8  read data, valid the sysclk after mem_re.
- busy  out  1  high while a frame is active (ce low, state not IDLE).
- cmd_error  out  1  one-cycle pulse when an unknown opcode completes.

Behaviour:
- Reset values: sio_out=0, sio_oe=0, mem_addr=0, mem_wdata=0, mem_we=0, mem_re=0, busy=0, cmd_error=0, state=IDLE.
- Input sampling: sclk, ce and sio_in pass through a 2-FF synchronizer. rise/fall are one-cycle pulses from the synced sclk compared with its previous value.
- Latency: pin change to action is 3 sysclk. All bus decoding happens only on rise/fall pulses.
- Bit order: MSB first on every line. Quad nibble order is [7:4], then [3:0].
- Line roles: single-bit input on sio[0], single-bit output on sio[1]. Quad uses sio[3:0].
- Sampling and driving: the responder samples on rise and updates sio_out on fall. The master therefore sees stable data at its posedge.
- State machine (all states return to IDLE when synced ce is high):
  - IDLE: ce falls -> CMD, bit counter cleared.
  - CMD: 8 rises on sio[0]. Opcode 0x02 (SPI write), 0x03 (SPI read), 0x38 (quad write) or 0xEB (quad read) -> ADDR. Any other opcode -> IGNORE, with cmd_error pulsed once.
  - ADDR: 24 bits, serial for 0x02/0x03, 6 nibbles for 0x38/0xEB. On the final rise, load mem_addr. Then:
    - for 0x03, pulse mem_re -> READ_DATA;
    - for 0xEB -> DUMMY;
    - for writes -> WRITE_DATA.
  - DUMMY: count QREAD_WAIT rises. Pulse mem_re on the first rise. On the last rise -> READ_DATA.
  - READ_DATA: latch mem_rdata into the shift register one cycle after mem_re. sio_oe = 4'b0010 (SPI) or 4'b1111 (quad).
    - Each fall drives the next bit or nibble.
    - When the first bit/nibble of a byte is driven, increment mem_addr and pulse mem_re, prefetching the next byte.
  - WRITE_DATA: shift 8 bits or 2 nibbles. On the byte-completing rise, put the byte on mem_wdata and pulse mem_we with the current mem_addr. Next cycle increment mem_addr.
  - IGNORE: sio_oe=0; stay until ce high.
- Address arithmetic: mem_addr increments modulo 2^ADDR_WIDTH. 0xFFFF+1 -> 0x0000 at the default width.
- ce deasserted mid-frame: return to IDLE and clear sio_oe the same cycle. A partial write byte is discarded, with no mem_we. A pending prefetch is dropped.
- Reset mid-frame: same as ce deassert, plus all outputs return to their reset values.
- sclk with ce high: ignored.
- sio_oe is 0 in every state except READ_DATA.
- rise and fall never coincide, since they come from one synced signal.
- Reads beyond the first byte stream continuously until ce rises.

Decomposition:
- psram_pkg holds:
  - opcode constants CMD_SPI_WRITE=8'h02, CMD_SPI_READ=8'h03, CMD_QSPI_WRITE=8'h38, CMD_QSPI_READ=8'hEB;
  - the ResponderState enum {IDLE, CMD, ADDR, DUMMY, READ_DATA, WRITE_DATA, IGNORE};
  - the operation_status enum, shared with the master.
- One sub-module, spi_pin_sync: 2-FF synchronizer plus edge detect. Outputs ce_n_s, sio_s[3:0], sclk_rise, sclk_fall.

Test Plan:
- Reset asserted for 2 cycles with ce held low -> all outputs 0, busy=0, and no state advance until ce toggles high then low.
- SPI write 0x02, addr 0x000010, data 0xA5 0x3C -> mem_we pulses twice: (0x0010, 0xA5), then (0x0011, 0x3C).
- Quad read 0xEB, addr 0x000020, QREAD_WAIT=6, memory holds 0x5A at 0x20 and 0xC3 at 0x21 -> the master's posedges sample nibbles 5, A, C, 3. sio_oe=4'hF only during data.
- Quad write 0x38, addr 0x00FFFF, data 0x11 0x22 -> writes (0xFFFF, 0x11) then (0x0000, 0x22).
- Opcode 0x9F -> cmd_error pulses once, sio_oe stays 0, no mem strobes until ce high.
- SPI write aborted by ce high after 5 data bits -> no mem_we, busy=0 within 3 sysclk. A following 0x03 read at 0x10 returns the old contents on sio[1].

Source files
------------

// File: rtl/psram_pkg.sv
`timescale 1ns/1ps
// Shared PSRAM bus definitions: opcodes, responder states and the
// operation status enum used by both ends of the SPI/QSPI link.
package psram_pkg;

  localparam logic [7:0] CMD_SPI_WRITE  = 8'h02;
  localparam logic [7:0] CMD_SPI_READ   = 8'h03;
  localparam logic [7:0] CMD_QSPI_WRITE = 8'h38;
  localparam logic [7:0] CMD_QSPI_READ  = 8'hEB;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    READ_DATA,
    WRITE_DATA,
    IGNORE
  } responder_state_t;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_BUSY,
    OP_DONE,
    OP_ERROR
  } operation_status_t;

  function automatic logic op_known(input logic [7:0] op);
    return (op == CMD_SPI_WRITE) || (op == CMD_SPI_READ) ||
           (op == CMD_QSPI_WRITE) || (op == CMD_QSPI_READ);
  endfunction

  function automatic logic op_quad(input logic [7:0] op);
    return (op == CMD_QSPI_WRITE) || (op == CMD_QSPI_READ);
  endfunction

  function automatic logic op_read(input logic [7:0] op);
    return (op == CMD_SPI_READ) || (op == CMD_QSPI_READ);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer for the SPI pins plus sclk edge pulses.
// Reset parks everything low so a ce held low through reset is no fall.
module spi_pin_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       ce,
  input  logic [3:0] sio_in,
  output logic       ce_n_s,
  output logic [3:0] sio_s,
  output logic       sclk_rise,
  output logic       sclk_fall
);

  // bit 5 = ce, bit 4 = sclk, bits 3:0 = sio
  logic [5:0] meta_q, meta_d;
  logic [5:0] sync_q, sync_d;
  logic       sclk_prev_q, sclk_prev_d;

  always_comb begin
    meta_d      = {ce, sclk, sio_in};
    sync_d      = meta_q;
    sclk_prev_d = sync_q[4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q      <= '0;
      sync_q      <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      meta_q      <= meta_d;
      sync_q      <= sync_d;
      sclk_prev_q <= sclk_prev_d;
    end
  end

  assign ce_n_s    = sync_q[5];
  assign sio_s     = sync_q[3:0];
  assign sclk_rise = sync_q[4] & ~sclk_prev_q;
  assign sclk_fall = ~sync_q[4] & sclk_prev_q;

endmodule

// File: rtl/psram_spi_responder.sv
`timescale 1ns/1ps
// SPI/QSPI PSRAM target: decodes master frames from oversampled pins
// and drives a byte-wide memory port with read prefetch.
module psram_spi_responder
  import psram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int QREAD_WAIT = 6
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  ce,
  input  logic [3:0]            sio_in,
  output logic [3:0]            sio_out,
  output logic [3:0]            sio_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  cmd_error
);

  localparam logic [4:0] DUMMY_LAST = 5'(QREAD_WAIT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic       ce_n_s;
  logic [3:0] sio_s;
  logic       rise;
  logic       fall;

  spi_pin_sync u_sync (
    .clk       (sysclk),
    .reset     (reset),
    .sclk      (sclk),
    .ce        (ce),
    .sio_in    (sio_in),
    .ce_n_s    (ce_n_s),
    .sio_s     (sio_s),
    .sclk_rise (rise),
    .sclk_fall (fall)
  );

  responder_state_t state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        quad_q, quad_d;
  logic        rd_q, rd_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  rd_buf_q, rd_buf_d;
  logic [ADDR_WIDTH-2:0] addr_sh_q, addr_sh_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        mem_re_q, mem_re_d;
  logic        lat_q, lat_d;
  logic        busy_q, busy_d;
  logic        cmd_error_q, cmd_error_d;
  logic        ce_prev_q, ce_prev_d;
  logic [3:0]  sio_out_q, sio_out_d;
  logic [3:0]  sio_oe_q, sio_oe_d;

  logic [7:0]  sh_in;
  logic [7:0]  cmd_byte;
  logic [7:0]  out_byte;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [4:0]  last_addr;
  logic [4:0]  last_data;

  always_comb begin
    sh_in    = quad_q ? {sh_q[3:0], sio_s} : {sh_q[6:0], sio_s[0]};
    cmd_byte = {sh_q[6:0], sio_s[0]};
    addr_in  = quad_q ? {addr_sh_q[ADDR_WIDTH-5:0], sio_s}
                      : {addr_sh_q, sio_s[0]};
    out_byte  = (cnt_q == 5'd0) ? rd_buf_q : sh_q;
    last_addr = quad_q ? 5'd5 : 5'd23;
    last_data = quad_q ? 5'd1 : 5'd7;

    state_d     = state_q;
    cnt_d       = cnt_q;
    quad_d      = quad_q;
    rd_d        = rd_q;
    sh_d        = sh_q;
    rd_buf_d    = rd_buf_q;
    addr_sh_d   = addr_sh_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    lat_d       = mem_re_q;
    cmd_error_d = 1'b0;
    ce_prev_d   = ce_n_s;
    sio_out_d   = sio_out_q;

    if (mem_we_q) mem_addr_d = mem_addr_q + ADDR_ONE;
    if (lat_q) rd_buf_d = mem_rdata;

    if (ce_n_s) begin
      state_d = IDLE;
      lat_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ce_prev_q) begin
            state_d = CMD;
            cnt_d   = 5'd0;
          end
        end
        CMD: begin
          if (rise) begin
            sh_d  = cmd_byte;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd7) begin
              cnt_d  = 5'd0;
              quad_d = op_quad(cmd_byte);
              rd_d   = op_read(cmd_byte);
              if (op_known(cmd_byte)) begin
                state_d = ADDR;
              end else begin
                state_d     = IGNORE;
                cmd_error_d = 1'b1;
              end
            end
          end
        end
        ADDR: begin
          if (rise) begin
            addr_sh_d = addr_in[ADDR_WIDTH-2:0];
            cnt_d     = cnt_q + 5'd1;
            if (cnt_q == last_addr) begin
              cnt_d      = 5'd0;
              mem_addr_d = addr_in;
              if (!rd_q) begin
                state_d = WRITE_DATA;
              end else if (quad_q) begin
                state_d = DUMMY;
              end else begin
                state_d  = READ_DATA;
                mem_re_d = 1'b1;
              end
            end
          end
        end
        DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd0) mem_re_d = 1'b1;
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 5'd0;
              state_d = READ_DATA;
            end
          end
        end
        READ_DATA: begin
          if (fall) begin
            // first unit of a byte comes from the prefetch buffer
            if (cnt_q == 5'd0) begin
              mem_addr_d = mem_addr_q + ADDR_ONE;
              mem_re_d   = 1'b1;
            end
            sio_out_d = quad_q ? out_byte[7:4]
                               : {2'b00, out_byte[7], 1'b0};
            sh_d  = quad_q ? {out_byte[3:0], 4'h0}
                           : {out_byte[6:0], 1'b0};
            cnt_d = (cnt_q == last_data) ? 5'd0 : cnt_q + 5'd1;
          end
        end
        WRITE_DATA: begin
          if (rise) begin
            sh_d  = sh_in;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == last_data) begin
              cnt_d       = 5'd0;
              mem_wdata_d = sh_in;
              mem_we_d    = 1'b1;
            end
          end
        end
        IGNORE: begin
          state_d = IGNORE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (state_d == READ_DATA) begin
      sio_oe_d = quad_d ? 4'hF : 4'h2;
    end else begin
      sio_oe_d  = 4'h0;
      sio_out_d = 4'h0;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quad_q      <= 1'b0;
      rd_q        <= 1'b0;
      sh_q        <= '0;
      rd_buf_q    <= '0;
      addr_sh_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      lat_q       <= 1'b0;
      busy_q      <= 1'b0;
      cmd_error_q <= 1'b0;
      ce_prev_q   <= 1'b0;
      sio_out_q   <= '0;
      sio_oe_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quad_q      <= quad_d;
      rd_q        <= rd_d;
      sh_q        <= sh_d;
      rd_buf_q    <= rd_buf_d;
      addr_sh_q   <= addr_sh_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      lat_q       <= lat_d;
      busy_q      <= busy_d;
      cmd_error_q <= cmd_error_d;
      ce_prev_q   <= ce_prev_d;
      sio_out_q   <= sio_out_d;
      sio_oe_q    <= sio_oe_d;
    end
  end

  assign sio_out   = sio_out_q;
  assign sio_oe    = sio_oe_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign busy      = busy_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_psram_spi_responder.sv
`timescale 1ns/1ps
// Bench for psram_spi_responder: acts as bus master and memory,
// with a reference memory and expected-write queue as the model.
module tb_psram_spi_responder;

  localparam int HALF = 80;

  logic        sysclk = 1'b0;
  logic        reset;
  logic        sclk;
  logic        ce;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic [3:0]  sio_oe;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;
  logic        cmd_error;

  always #5 sysclk = ~sysclk;

  psram_spi_responder #(.ADDR_WIDTH(16), .QREAD_WAIT(6)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .sclk      (sclk),
    .ce        (ce),
    .sio_in    (sio_in),
    .sio_out   (sio_out),
    .sio_oe    (sio_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .cmd_error (cmd_error)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  logic        started    = 1'b0;
  logic        re_allowed = 1'b0;
  logic [3:0]  allowed_oe = 4'h0;
  logic [23:0] exp_q[$];
  logic [7:0]  mem [65536];
  logic [7:0]  ref_mem [65536];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always @(posedge sysclk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge sysclk) begin
    if (started) begin
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", {mem_addr, mem_wdata}, 24'h0);
          if ({mem_addr, mem_wdata} == 24'h0) begin
            n_fail++;
            $display("FAIL unexpected_we: got strobe expected none");
          end
        end else begin
          chk("we_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
        end
      end
      if (mem_re) chk("re_allowed", 32'(re_allowed), 32'd1);
      n_tests++;
      if (sio_oe != 4'h0 && sio_oe != allowed_oe) begin
        n_fail++;
        $display("FAIL sio_oe: got %0h expected 0 or %0h",
                 sio_oe, allowed_oe);
      end
      if (cmd_error) err_cnt++;
    end
  end

  task automatic clk_bit(input logic [3:0] v);
    sio_in = v;
    #HALF sclk = 1'b1;
    #HALF sclk = 1'b0;
  endtask

  task automatic read_unit(output logic [3:0] v, output logic [3:0] oe);
    #HALF;
    v  = sio_out;
    oe = sio_oe;
    sclk = 1'b1;
    #HALF sclk = 1'b0;
  endtask

  task automatic send_spi(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) clk_bit({3'b000, b[i]});
  endtask

  task automatic send_addr(input logic quad, input logic [23:0] a);
    if (quad) for (int i = 5; i >= 0; i--) clk_bit(a[i*4 +: 4]);
    else for (int i = 23; i >= 0; i--) clk_bit({3'b000, a[i]});
  endtask

  task automatic end_frame();
    #HALF ce = 1'b1;
    repeat (6) @(posedge sysclk);
    #2;
    re_allowed = 1'b0;
    allowed_oe = 4'h0;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge sysclk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge sysclk);
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic frame_write(input logic [7:0] op, input logic quad,
                             input logic [23:0] a, input int n,
                             input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0]  d;
    logic [15:0] ma;
    ce = 1'b0;
    #HALF;
    send_spi(op);
    send_addr(quad, a);
    for (int i = 0; i < n; i++) begin
      d  = (i == 0) ? d0 : d1;
      ma = a[15:0] + 16'(i);
      exp_q.push_back({ma, d});
      ref_mem[ma] = d;
      if (quad) begin
        clk_bit(d[7:4]);
        clk_bit(d[3:0]);
      end else begin
        send_spi(d);
      end
    end
    end_frame();
    chk("wr_drain", exp_q.size(), 0);
    chk("wr_busy_idle", 32'(busy), 0);
  endtask

  task automatic frame_read(input logic [7:0] op, input logic quad,
                            input logic [23:0] a, input int n,
                            output logic [7:0] b0, output logic [7:0] b1);
    logic [7:0]  b;
    logic [3:0]  v, oe;
    logic [15:0] ma;
    b0 = '0;
    b1 = '0;
    re_allowed = 1'b1;
    allowed_oe = quad ? 4'hF : 4'h2;
    ce = 1'b0;
    #HALF;
    send_spi(op);
    send_addr(quad, a);
    if (quad) begin
      for (int i = 0; i < 6; i++) begin
        sio_in = 4'h0;
        #HALF;
        chk("dummy_oe", 32'(sio_oe), 0);
        sclk = 1'b1;
        #HALF sclk = 1'b0;
      end
    end
    for (int i = 0; i < n; i++) begin
      b = '0;
      for (int u = 0; u < (quad ? 2 : 8); u++) begin
        read_unit(v, oe);
        chk("rd_oe", 32'(oe), quad ? 32'hF : 32'h2);
        b = quad ? {b[3:0], v} : {b[6:0], v[1]};
      end
      ma = a[15:0] + 16'(i);
      chk("rd_byte", 32'(b), 32'(ref_mem[ma]));
      if (i == 0) b0 = b;
      else b1 = b;
    end
    end_frame();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;
    int e0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    ce = 1'b0; sclk = 1'b0; sio_in = 4'h0; reset = 1'b1;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk("rst_sio_out", 32'(sio_out), 0);
    chk("rst_sio_oe", 32'(sio_oe), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_strobes", {mem_wdata, mem_we, mem_re, busy, cmd_error}, 0);
    reset = 1'b0;
    started = 1'b1;
    for (int i = 0; i < 65536; i += 4096) mem[i] = 8'h00;
    @(posedge sysclk); #2;
    send_spi(8'h03);
    send_addr(1'b0, 24'h000010);
    chk("no_advance_busy", 32'(busy), 0);
    end_frame();

    preload(16'h0020, 8'h5A);
    preload(16'h0021, 8'hC3);
    @(posedge sysclk); #2;

    frame_write(8'h02, 1'b0, 24'h000010, 2, 8'hA5, 8'h3C);
    chk("spi_wr_mem10", 32'(mem[16'h0010]), 32'hA5);
    chk("spi_wr_mem11", 32'(mem[16'h0011]), 32'h3C);

    frame_read(8'hEB, 1'b1, 24'h000020, 2, b0, b1);
    chk("qrd_nib0", 32'(b0[7:4]), 32'h5);
    chk("qrd_nib1", 32'(b0[3:0]), 32'hA);
    chk("qrd_nib2", 32'(b1[7:4]), 32'hC);
    chk("qrd_nib3", 32'(b1[3:0]), 32'h3);

    frame_write(8'h38, 1'b1, 24'h00FFFF, 2, 8'h11, 8'h22);
    chk("qwr_memFFFF", 32'(mem[16'hFFFF]), 32'h11);
    chk("qwr_mem0000", 32'(mem[16'h0000]), 32'h22);

    e0 = err_cnt;
    ce = 1'b0;
    #HALF;
    send_spi(8'h9F);
    for (int i = 0; i < 16; i++) clk_bit(4'hF);
    chk("bad_op_busy", 32'(busy), 1);
    end_frame();
    chk("bad_op_err", err_cnt - e0, 1);

    ce = 1'b0;
    #HALF;
    send_spi(8'h02);
    send_addr(1'b0, 24'h000010);
    for (int i = 0; i < 5; i++) clk_bit({3'b000, i[0]});
    chk("abort_busy_hi", 32'(busy), 1);
    #HALF ce = 1'b1;
    repeat (3) @(posedge sysclk);
    #1;
    chk("abort_busy_lo", 32'(busy), 0);
    repeat (10) @(posedge sysclk);
    #2;
    chk("abort_no_we", exp_q.size(), 0);
    chk("abort_mem10", 32'(mem[16'h0010]), 32'hA5);

    frame_read(8'h03, 1'b0, 24'h000010, 1, b0, b1);
    chk("spi_rd_old", 32'(b0), 32'hA5);

    frame_read(8'h03, 1'b0, 24'h000010, 2, b0, b1);
    chk("spi_rd_stream", 32'(b1), 32'h3C);

    chk("err_total", err_cnt, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
